// File: rtl/multibit_fifo_pkg.sv
// Shared types and pointer helpers for the multi-entry CDC FIFO (read and write controllers).
// Helpers work on a 32-bit container; callers zero-extend narrower pointers.
package multibit_fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int PTR_MAX_W       = 32;

  typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;
  typedef logic [PTR_MAX_W-1:0]     ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input ptr_max_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/multibit_fifo_gray_sync.sv
// Vector synchronizer for a Gray-coded pointer crossing into the clk domain.
// Only valid for Gray-coded (single-bit-change) inputs; all flops carry ASYNC_REG and need a false path on the input.
module multibit_fifo_gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/multibit_fifo_rd_ctrl.sv
// Read-side controller of the multi-entry CDC FIFO: syncs the write pointer, owns the read
// pointer, addresses the external RAM and drives a registered valid/ready output stream.
module multibit_fifo_rd_ctrl
  import multibit_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  err_gray
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = PW'(2 ** ADDR_WIDTH);

  logic [PW-1:0]         wsync_gray, wsync_prev, wsync_bin;
  logic [PW-1:0]         rptr_bin, rptr_next, ram_fill, level_next;
  logic                  empty, load, valid_next, gray_jump, overfill;
  logic [DATA_WIDTH-1:0] data_next;

  multibit_fifo_gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (clk),
    .reset (reset),
    .d     (wptr_gray),
    .q     (wsync_gray)
  );

  assign wsync_bin = PW'(gray2bin(ptr_max_t'(wsync_gray)));
  assign ram_raddr = rptr_bin[ADDR_WIDTH-1:0];

  // Full-width compare: the extra MSB distinguishes empty from a lapped (full) pointer.
  always_comb begin
    empty      = (wsync_bin == rptr_bin);
    load       = !empty && (!out_valid || out_ready);
    rptr_next  = load ? rptr_bin + PW'(1) : rptr_bin;
    data_next  = load ? ram_rdata : out_data;
    valid_next = out_valid;
    if (load)                        valid_next = 1'b1;
    else if (out_valid && out_ready) valid_next = 1'b0;
    ram_fill   = wsync_bin - rptr_next;
    level_next = ram_fill + PW'(valid_next);
    gray_jump  = popcount(ptr_max_t'(wsync_gray ^ wsync_prev)) > 1;
    overfill   = (wsync_bin - rptr_bin) > DEPTH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_bin   <= '0;
      rptr_gray  <= '0;
      wsync_prev <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      level      <= '0;
      err_gray   <= 1'b0;
    end else begin
      rptr_bin   <= rptr_next;
      rptr_gray  <= PW'(bin2gray(ptr_max_t'(rptr_next)));
      wsync_prev <= wsync_gray;
      out_valid  <= valid_next;
      out_data   <= data_next;
      level      <= level_next;
      if (gray_jump || overfill) err_gray <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multibit_fifo_rd_ctrl.sv
// Directed scoreboard bench for multibit_fifo_rd_ctrl with a Gray-counter write model and mem[i]=i+0x100.
module tb_multibit_fifo_rd_ctrl;

  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW:0]   wptr_gray;
  logic [AW:0]   rptr_gray;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [AW:0]   level;
  logic          err_gray;

  int       vec_cnt = 0;
  int       err_cnt = 0;
  int       cyc     = 0;
  int       pops    = 0;
  int       first_pop, last_pop;
  int       wbin    = 0;
  bit [DW-1:0] sb[$];

  always #5 clk = ~clk;

  assign ram_rdata = 32'h100 + DW'(ram_raddr);

  multibit_fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .wptr_gray (wptr_gray),
    .rptr_gray (rptr_gray),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .err_gray  (err_gray)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_word();
    sb.push_back(32'h100 + 32'(wbin % 8));
    wbin      = (wbin + 1) % 16;
    wptr_gray = 4'(wbin ^ (wbin >> 1));
  endtask

  // Inputs set at negedge; a transfer is judged with the ready value the next posedge will see.
  task automatic step(input logic rdy, input logic do_wr);
    @(negedge clk);
    cyc++;
    out_ready = rdy;
    if (do_wr) write_word();
    #1;
    if (out_valid && out_ready) begin
      chk("sb_underflow", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) chk("pop_data", 64'(out_data), 64'(sb.pop_front()));
      if (pops == 0) first_pop = cyc;
      last_pop = cyc;
      pops++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b0; wbin = 0; wptr_gray = '0;
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    pops = 0;
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; wptr_gray = '0;

    // 1: reset state, idle with wptr=0
    do_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_rptr", 64'(rptr_gray), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_err", 64'(err_gray), 64'd0);
    repeat (5) step(1'b1, 1'b0);
    chk("idle_valid", 64'(out_valid), 64'd0);

    // 2: latency of one word through a 2-stage sync
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("lat_n0", 64'(out_valid), 64'd0);
    step(1'b0, 1'b0);
    chk("lat_n1", 64'(out_valid), 64'd0);
    step(1'b0, 1'b0);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_data", 64'(out_data), 64'h100);
    chk("lat_level", 64'(level), 64'd1);
    chk("lat_rptr", 64'(rptr_gray), 64'h1);
    step(1'b1, 1'b0);
    chk("lat_pops", 64'(pops), 64'd1);
    step(1'b1, 1'b0);
    chk("lat_drained", 64'(out_valid), 64'd0);

    // 3: streaming 20 words, pointer wraps past 15
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    chk("stream_pops", 64'(pops), 64'd20);
    chk("stream_span", 64'(last_pop - first_pop), 64'd19);
    chk("stream_sb_left", 64'(sb.size()), 64'd0);
    chk("stream_rptr", 64'(rptr_gray), 64'h6);
    chk("stream_err", 64'(err_gray), 64'd0);
    chk("stream_level", 64'(level), 64'd0);

    // 4: backpressure with 8 words outstanding
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      chk("bp_hold_data", 64'(out_data), 64'h100);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    chk("bp_level", 64'(level), 64'd8);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    chk("bp_pops", 64'(pops), 64'd8);
    chk("bp_err", 64'(err_gray), 64'd0);

    // 5: two-bit Gray jump sets the sticky error
    do_reset();
    @(negedge clk);
    wptr_gray = 4'h3;
    repeat (4) step(1'b0, 1'b0);
    chk("gerr_set", 64'(err_gray), 64'd1);
    repeat (6) step(1'b0, 1'b0);
    chk("gerr_sticky", 64'(err_gray), 64'd1);
    sb.delete();
    do_reset();
    chk("gerr_cleared", 64'(err_gray), 64'd0);

    // 6: reset in the middle of a stream
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    chk("mid_level", 64'(level), 64'd5);
    chk("mid_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    reset = 1'b1; wbin = 0; wptr_gray = '0;
    sb.delete();
    @(negedge clk);
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_rptr", 64'(rptr_gray), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    reset = 1'b0;
    pops = 0;
    repeat (6) step(1'b1, 1'b0);
    chk("mid_no_spurious", 64'(out_valid), 64'd0);
    chk("mid_pops", 64'(pops), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
